// File: rtl/sys_host_pkg.sv
// rtl/sys_host_pkg.sv - opcodes, command/state encodings and frame helpers for sys_host_ctrl
//
// Shared by sys_host_ctrl and rsp_timer. Frame layout (byte 0 first):
//   RF write    : AA, addr, data            (0 response bytes)
//   RF read     : BB, addr                  (1 response byte)
//   ALU operands: CC, A, B, {0,fun}         (2 response bytes)
//   ALU no-op   : DD, {0,fun}               (2 response bytes)
package sys_host_pkg;

    localparam logic [7:0] OP_RF_WR   = 8'hAA;
    localparam logic [7:0] OP_RF_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] FRM_LEN_RF_WR   = 3'd3;
    localparam logic [2:0] FRM_LEN_RF_RD   = 3'd2;
    localparam logic [2:0] FRM_LEN_ALU_OP  = 3'd4;
    localparam logic [2:0] FRM_LEN_ALU_NOP = 3'd2;

    localparam logic [1:0] RSP_LEN_RF_WR   = 2'd0;
    localparam logic [1:0] RSP_LEN_RF_RD   = 2'd1;
    localparam logic [1:0] RSP_LEN_ALU_OP  = 2'd2;
    localparam logic [1:0] RSP_LEN_ALU_NOP = 2'd2;

    function automatic logic [2:0] frame_len(input cmd_type_e t);
        logic [2:0] len;
        case (t)
            CMD_RF_WR:  len = FRM_LEN_RF_WR;
            CMD_RF_RD:  len = FRM_LEN_RF_RD;
            CMD_ALU_OP: len = FRM_LEN_ALU_OP;
            default:    len = FRM_LEN_ALU_NOP;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] rsp_len(input cmd_type_e t);
        logic [1:0] len;
        case (t)
            CMD_RF_WR:  len = RSP_LEN_RF_WR;
            CMD_RF_RD:  len = RSP_LEN_RF_RD;
            CMD_ALU_OP: len = RSP_LEN_ALU_OP;
            default:    len = RSP_LEN_ALU_NOP;
        endcase
        return len;
    endfunction

    // Byte idx of the frame for a command; idx beyond the frame is never requested.
    function automatic logic [7:0] frame_byte(
        input cmd_type_e  t,
        input logic [2:0] idx,
        input logic [7:0] addr,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [3:0] fun
    );
        logic [7:0] byte_out;
        byte_out = 8'h00;
        case (t)
            CMD_RF_WR: begin
                case (idx)
                    3'd0:    byte_out = OP_RF_WR;
                    3'd1:    byte_out = addr;
                    default: byte_out = a;
                endcase
            end
            CMD_RF_RD: begin
                byte_out = (idx == 3'd0) ? OP_RF_RD : addr;
            end
            CMD_ALU_OP: begin
                case (idx)
                    3'd0:    byte_out = OP_ALU_OP;
                    3'd1:    byte_out = a;
                    3'd2:    byte_out = b;
                    default: byte_out = {4'b0000, fun};
                endcase
            end
            default: begin
                byte_out = (idx == 3'd0) ? OP_ALU_NOP : {4'b0000, fun};
            end
        endcase
        return byte_out;
    endfunction

endpackage

// File: rtl/sys_host_ctrl_rsp_timer.sv
// rtl/sys_host_ctrl_rsp_timer.sv - response inactivity timer for sys_host_ctrl
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : zero the counter (wins over en)
//   en         : count one idle cycle
//   expire     : this idle cycle is the TMO_CYC-th one since the last clear
module rsp_timer
#(
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_CYC = 16'hFFFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TMO_W'(1);
        end
    end

    // Fires on the idle cycle whose increment would bring the count to TMO_CYC.
    assign expire = en && !clr && (count == TMO_CYC - TMO_W'(1));

endmodule

// File: rtl/sys_host_ctrl.sv
// rtl/sys_host_ctrl.sv - host-side command initiator for the UART register/ALU protocol
//
// Ports:
//   CLK, RST                       : clock, asynchronous active-low reset
//   CMD_VLD/CMD_RDY                : command handshake, CMD_RDY high only in IDLE
//   CMD_TYPE/ADDR/A/B/FUN          : command fields, captured on acceptance
//   TX_DATA/TX_VLD/TX_FULL         : frame bytes into the UART transmit FIFO
//   RX_DATA/RX_VLD                 : response bytes from the UART receiver
//   RSP_DATA/RSP_VLD/RSP_ERR       : completion pulse, response bytes, timeout flag
module sys_host_ctrl
#(
    parameter int                DATA_WIDTH = 8,
    parameter int                RF_ADDR    = 4,
    parameter int                TMO_W      = 16,
    parameter logic [TMO_W-1:0]  TMO_CYC    = 16'hFFFF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CMD_VLD,
    output logic                    CMD_RDY,
    input  logic [1:0]              CMD_TYPE,
    input  logic [RF_ADDR-1:0]      CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_A,
    input  logic [DATA_WIDTH-1:0]   CMD_B,
    input  logic [3:0]              CMD_FUN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VLD,
    input  logic                    TX_FULL,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_VLD,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_VLD,
    output logic                    RSP_ERR
);

    import sys_host_pkg::*;

    state_e     state;
    cmd_type_e  typ_q;
    cmd_type_e  typ_in;
    logic [7:0] addr_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [3:0] fun_q;
    logic [2:0] idx;
    logic [1:0] rx_cnt;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_expire;

    assign typ_in  = cmd_type_e'(CMD_TYPE);
    assign CMD_RDY = (state == IDLE);

    // The timer only runs while waiting for response bytes; each byte restarts it.
    assign tmr_clr = (state != WAIT) || RX_VLD;
    assign tmr_en  = (state == WAIT) && !RX_VLD;

    rsp_timer #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_rsp_timer (
        .clk    (CLK),
        .rst_n  (RST),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            typ_q    <= CMD_RF_WR;
            addr_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            idx      <= '0;
            rx_cnt   <= '0;
            TX_VLD   <= 1'b0;
            TX_DATA  <= '0;
            RSP_VLD  <= 1'b0;
            RSP_ERR  <= 1'b0;
            RSP_DATA <= '0;
        end else begin
            TX_VLD  <= 1'b0;
            RSP_VLD <= 1'b0;
            RSP_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_VLD) begin
                        typ_q    <= typ_in;
                        addr_q   <= 8'(CMD_ADDR);
                        a_q      <= 8'(CMD_A);
                        b_q      <= 8'(CMD_B);
                        fun_q    <= CMD_FUN;
                        rx_cnt   <= '0;
                        RSP_DATA <= '0;
                        state    <= SEND;
                        // Byte 0 goes out on the accept edge so it is visible in
                        // the very next cycle.
                        if (!TX_FULL) begin
                            TX_VLD  <= 1'b1;
                            TX_DATA <= DATA_WIDTH'(frame_byte(typ_in, 3'd0, 8'(CMD_ADDR),
                                                              8'(CMD_A), 8'(CMD_B), CMD_FUN));
                            idx     <= 3'd1;
                        end else begin
                            idx     <= 3'd0;
                        end
                    end
                end

                SEND: begin
                    if (idx == frame_len(typ_q)) begin
                        rx_cnt <= '0;
                        if (typ_q == CMD_RF_WR) begin
                            state   <= DONE;
                            RSP_VLD <= 1'b1;
                        end else begin
                            state   <= WAIT;
                        end
                    end else if (!TX_FULL) begin
                        TX_VLD  <= 1'b1;
                        TX_DATA <= DATA_WIDTH'(frame_byte(typ_q, idx, addr_q, a_q, b_q, fun_q));
                        idx     <= idx + 3'd1;
                    end
                end

                WAIT: begin
                    // A byte arriving on the expiry cycle is kept and restarts the timer.
                    if (RX_VLD) begin
                        if (rx_cnt == 2'd0) begin
                            RSP_DATA[DATA_WIDTH-1:0] <= RX_DATA;
                        end else begin
                            RSP_DATA[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_DATA;
                        end
                        rx_cnt <= rx_cnt + 2'd1;
                        if ((rx_cnt + 2'd1) == rsp_len(typ_q)) begin
                            state   <= DONE;
                            RSP_VLD <= 1'b1;
                        end
                    end else if (tmr_expire) begin
                        state   <= DONE;
                        RSP_VLD <= 1'b1;
                        RSP_ERR <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_host_ctrl.sv
// tb/tb_sys_host_ctrl.sv - self-checking bench for sys_host_ctrl
module tb_sys_host_ctrl;

    localparam int TMO = 20;

    logic        CLK;
    logic        RST;
    logic        CMD_VLD;
    logic        CMD_RDY;
    logic [1:0]  CMD_TYPE;
    logic [3:0]  CMD_ADDR;
    logic [7:0]  CMD_A;
    logic [7:0]  CMD_B;
    logic [3:0]  CMD_FUN;
    logic [7:0]  TX_DATA;
    logic        TX_VLD;
    logic        TX_FULL;
    logic [7:0]  RX_DATA;
    logic        RX_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_ERR;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
        int          nrsp;
        logic [7:0]  r0;
        logic [7:0]  r1;
        int          g0;
        int          g1;
        logic [31:0] full;
        bit          stray;
        logic [15:0] exp_data;
        bit          exp_err;
    } vec_t;

    sys_host_ctrl #(
        .DATA_WIDTH (8),
        .RF_ADDR    (4),
        .TMO_W      (16),
        .TMO_CYC    (16'(TMO))
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CMD_VLD  (CMD_VLD),
        .CMD_RDY  (CMD_RDY),
        .CMD_TYPE (CMD_TYPE),
        .CMD_ADDR (CMD_ADDR),
        .CMD_A    (CMD_A),
        .CMD_B    (CMD_B),
        .CMD_FUN  (CMD_FUN),
        .TX_DATA  (TX_DATA),
        .TX_VLD   (TX_VLD),
        .TX_FULL  (TX_FULL),
        .RX_DATA  (RX_DATA),
        .RX_VLD   (RX_VLD),
        .RSP_DATA (RSP_DATA),
        .RSP_VLD  (RSP_VLD),
        .RSP_ERR  (RSP_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Response outcome from the protocol rules: bytes arrive g0 cycles after the
    // last frame byte and g1 cycles after the first; more than TMO idle cycles
    // aborts. off is the RSP_VLD cycle relative to the last frame byte.
    function automatic void model_rsp(input vec_t v, output logic [15:0] d,
                                      output bit e, output int off);
        int         elen;
        int         anchor;
        int         gap [2];
        logic [7:0] rb [2];
        elen   = (v.typ == 2'd0) ? 0 : (v.typ == 2'd1) ? 1 : 2;
        gap[0] = v.g0;
        gap[1] = v.g1;
        rb[0]  = v.r0;
        rb[1]  = v.r1;
        d      = '0;
        e      = 1'b0;
        anchor = 0;
        off    = 1;
        for (int i = 0; i < elen; i++) begin
            if (i >= v.nrsp || gap[i] > TMO) begin
                e   = 1'b1;
                off = anchor + TMO + 1;
                return;
            end
            anchor     += gap[i];
            d[8*i +: 8] = rb[i];
            off         = anchor + 1;
        end
    endfunction

    task automatic run_txn(input string tag, input vec_t v);
        logic [7:0]  exp_frame[$];
        int          exp_cyc[$];
        logic [7:0]  got_frame[$];
        int          got_cyc[$];
        logic [15:0] m_data;
        bit          m_err;
        int          off;
        int          last_tx;
        int          rx0;
        int          rx1;
        int          rsp_cyc;
        int          k;
        int          wait_cnt;
        logic [15:0] held_data;
        logic        held_err;
        bit          seen;
        bit          rdy_early;

        case (v.typ)
            2'd0: begin exp_frame.push_back(8'hAA); exp_frame.push_back({4'h0, v.addr}); exp_frame.push_back(v.a); end
            2'd1: begin exp_frame.push_back(8'hBB); exp_frame.push_back({4'h0, v.addr}); end
            2'd2: begin exp_frame.push_back(8'hCC); exp_frame.push_back(v.a); exp_frame.push_back(v.b);
                        exp_frame.push_back({4'h0, v.fun}); end
            default: begin exp_frame.push_back(8'hDD); exp_frame.push_back({4'h0, v.fun}); end
        endcase
        // A byte goes out the cycle after each non-full cycle, starting at the accept cycle.
        k = 0;
        for (int c = 0; k < exp_frame.size(); c++) begin
            if (c >= 32 || !v.full[c]) begin
                exp_cyc.push_back(c + 1);
                k++;
            end
        end
        last_tx = exp_cyc[exp_cyc.size() - 1];
        rx0 = last_tx + v.g0;
        rx1 = rx0 + v.g1;
        model_rsp(v, m_data, m_err, off);

        wait_cnt = 0;
        while (!CMD_RDY && wait_cnt < 100) begin
            tick();
            wait_cnt++;
        end
        chk({tag, "_rdy_before"}, 32'(CMD_RDY), 32'd1);

        seen      = 1'b0;
        rdy_early = 1'b0;
        rsp_cyc   = -1;
        held_data = '0;
        held_err  = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            CMD_VLD = (t == 0);
            if (t == 0) begin
                CMD_TYPE = v.typ; CMD_ADDR = v.addr; CMD_A = v.a; CMD_B = v.b; CMD_FUN = v.fun;
            end else begin
                CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_A = 8'($urandom);
                CMD_B = 8'($urandom); CMD_FUN = 4'($urandom);
            end
            TX_FULL = (t < 32) ? v.full[t] : 1'b0;
            RX_VLD  = 1'b0;
            RX_DATA = 8'($urandom);
            if (v.stray && t <= 1) RX_VLD = 1'b1;
            if (v.nrsp > 0 && t == rx0) begin RX_VLD = 1'b1; RX_DATA = v.r0; end
            if (v.nrsp > 1 && t == rx1) begin RX_VLD = 1'b1; RX_DATA = v.r1; end
            @(negedge CLK);
            if (t >= 1 && CMD_RDY) rdy_early = 1'b1;
            if (TX_VLD) begin
                got_frame.push_back(TX_DATA);
                got_cyc.push_back(t);
            end
            if (RSP_VLD) begin
                seen      = 1'b1;
                rsp_cyc   = t;
                held_data = RSP_DATA;
                held_err  = RSP_ERR;
            end
            tick();
        end
        CMD_VLD = 1'b0;
        TX_FULL = 1'b0;
        RX_VLD  = 1'b0;

        chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, "_rdy_busy"}, 32'(rdy_early), 32'd0);
        chk({tag, "_frame_len"}, got_frame.size(), exp_frame.size());
        for (int i = 0; i < exp_frame.size() && i < got_frame.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_frame[i]), 32'(exp_frame[i]));
            chk($sformatf("%s_byte%0d_cyc", tag, i), got_cyc[i], exp_cyc[i]);
        end
        chk({tag, "_rsp_cyc"}, rsp_cyc, last_tx + off);
        chk({tag, "_rsp_data"}, 32'(held_data), 32'(v.exp_data));
        chk({tag, "_rsp_err"}, 32'(held_err), 32'(v.exp_err));
        // Cycle after completion: back in IDLE, response held.
        chk({tag, "_rdy_after"}, 32'(CMD_RDY), 32'd1);
        chk({tag, "_vld_pulse"}, 32'(RSP_VLD), 32'd0);
        chk({tag, "_rsp_hold"}, 32'(RSP_DATA), 32'(held_data));
    endtask

    vec_t        tbl[10];
    vec_t        rv;
    logic [15:0] md;
    bit          me;
    int          moff;
    logic [15:0] idle_data;

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        RST      = 1'b0;
        CMD_VLD  = 1'b0;
        CMD_TYPE = '0;
        CMD_ADDR = '0;
        CMD_A    = '0;
        CMD_B    = '0;
        CMD_FUN  = '0;
        TX_FULL  = 1'b0;
        RX_DATA  = '0;
        RX_VLD   = 1'b0;

        //          typ   addr   a      b      fun   n  r0     r1     g0  g1  full         stray exp_data  err
        tbl[0] = '{2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 0, 8'h00, 8'h00, 1,  1,  32'h0,       1'b0, 16'h0000, 1'b0};
        tbl[1] = '{2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1, 8'h7E, 8'h00, 3,  1,  32'h0,       1'b0, 16'h007E, 1'b0};
        tbl[2] = '{2'd2, 4'h0, 8'h12, 8'h34, 4'h0, 2, 8'h46, 8'h00, 2,  1,  32'h3C,      1'b0, 16'h0046, 1'b0};
        tbl[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h9, 1, 8'hAB, 8'h00, 2,  1,  32'h0,       1'b0, 16'h00AB, 1'b1};
        tbl[4] = '{2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1, 8'h5A, 8'h00, 1,  1,  32'h0,       1'b1, 16'h005A, 1'b0};
        tbl[5] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 2, 8'h11, 8'h22, 20, 20, 32'h0,       1'b0, 16'h2211, 1'b0};
        tbl[6] = '{2'd1, 4'h7, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 1,  1,  32'h0,       1'b0, 16'h0000, 1'b1};
        tbl[7] = '{2'd2, 4'h0, 8'hFF, 8'h01, 4'hF, 2, 8'h00, 8'h01, 1,  5,  32'h1,       1'b0, 16'h0100, 1'b0};
        tbl[8] = '{2'd2, 4'h0, 8'h55, 8'hAA, 4'h2, 2, 8'hC3, 8'h99, 4,  25, 32'h0,       1'b0, 16'h00C3, 1'b1};
        tbl[9] = '{2'd0, 4'hA, 8'h77, 8'h00, 4'h0, 0, 8'h00, 8'h00, 1,  1,  32'h5,       1'b1, 16'h0000, 1'b0};

        // Reset values.
        repeat (3) @(posedge CLK);
        #3;
        chk("rst_cmd_rdy",  32'(CMD_RDY),  32'd1);
        chk("rst_tx_vld",   32'(TX_VLD),   32'd0);
        chk("rst_tx_data",  32'(TX_DATA),  32'd0);
        chk("rst_rsp_vld",  32'(RSP_VLD),  32'd0);
        chk("rst_rsp_err",  32'(RSP_ERR),  32'd0);
        chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Stray receive pulses while idle must not change anything.
        idle_data = RSP_DATA;
        for (int i = 0; i < 3; i++) begin
            RX_VLD  = 1'b1;
            RX_DATA = 8'($urandom);
            tick();
        end
        RX_VLD = 1'b0;
        tick();
        chk("idle_rx_rdy",  32'(CMD_RDY),  32'd1);
        chk("idle_rx_vld",  32'(RSP_VLD),  32'd0);
        chk("idle_rx_data", 32'(RSP_DATA), 32'(idle_data));
        run_txn("post_idle_rx", tbl[1]);

        // Reset in the middle of sending a frame.
        CMD_TYPE = 2'd2; CMD_ADDR = 4'h0; CMD_A = 8'h12; CMD_B = 8'h34; CMD_FUN = 4'h5;
        TX_FULL  = 1'b0;
        CMD_VLD  = 1'b1;
        tick();
        CMD_VLD  = 1'b0;
        tick();
        chk("pre_rst_tx_vld",  32'(TX_VLD),  32'd1);
        chk("pre_rst_tx_data", 32'(TX_DATA), 32'h12);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_cmd_rdy",  32'(CMD_RDY),  32'd1);
        chk("mid_rst_tx_vld",   32'(TX_VLD),   32'd0);
        chk("mid_rst_tx_data",  32'(TX_DATA),  32'd0);
        chk("mid_rst_rsp_vld",  32'(RSP_VLD),  32'd0);
        chk("mid_rst_rsp_err",  32'(RSP_ERR),  32'd0);
        chk("mid_rst_rsp_data", 32'(RSP_DATA), 32'd0);
        @(posedge CLK);
        #3 RST = 1'b1;
        tick();
        run_txn("after_rst", tbl[0]);

        // Randomized commands against the protocol model.
        for (int n = 0; n < 40; n++) begin
            rv.typ   = 2'($urandom_range(3));
            rv.addr  = 4'($urandom);
            rv.a     = 8'($urandom);
            rv.b     = 8'($urandom);
            rv.fun   = 4'($urandom);
            rv.nrsp  = int'($urandom_range(2));
            rv.r0    = 8'($urandom);
            rv.r1    = 8'($urandom);
            rv.g0    = int'($urandom_range(24, 1));
            rv.g1    = int'($urandom_range(24, 1));
            rv.full  = $urandom & $urandom;
            rv.stray = 1'($urandom);
            model_rsp(rv, md, me, moff);
            rv.exp_data = md;
            rv.exp_err  = me;
            run_txn($sformatf("rnd%0d", n), rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
